// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - parametrised pipeline-stage register with 2-entry skid buffer
//
// Purpose: sits on a CPU pipeline stage boundary. The upstream side has a
// valid/ready handshake. A main register drives the outputs and a skid
// register absorbs one extra beat when downstream stalls. Flush kills every
// held entry and bubbles the control field. A saturating counter records
// the cycles in which the stage holds a valid instruction that downstream
// refuses.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous kill of all held entries
//   clr_stats  synchronous clear of stall_cnt (wins over increment)
//   in_valid   upstream has an instruction
//   in_ready   stage can accept this cycle (registered, no path from out_ready)
//   in_ctrl    upstream control field
//   in_data    upstream payload
//   out_valid  stage output holds a valid instruction
//   out_ready  downstream accepts this cycle
//   out_ctrl   control field to next stage (BUBBLE_CTRL whenever out_valid=0)
//   out_data   payload to next stage
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0

module pipe_stage_skid #(
  parameter int                 CTRL_W      = 16,
  parameter int                 DATA_W      = 192,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              clr_stats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // What the main register loads on this edge.
  typedef enum logic [1:0] {
    M_KEEP   = 2'd0,
    M_IN     = 2'd1,
    M_SKID   = 2'd2,
    M_BUBBLE = 2'd3
  } main_sel_t;

  state_t      state, state_nxt;
  main_sel_t   main_sel;
  logic        skid_load;
  logic        skid_bubble;
  logic        accept;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              out_valid_q, in_ready_q;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign accept    = in_valid & in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  // State register. out_valid and in_ready are registered copies of the
  // next-state decode so neither output has a combinational input path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt != S_EMPTY);
      in_ready_q  <= (state_nxt != S_FULL);
    end
  end

  // Next state and register load controls.
  always_comb begin
    state_nxt   = state;
    main_sel    = M_KEEP;
    skid_load   = 1'b0;
    skid_bubble = 1'b0;
    if (flush) begin
      state_nxt   = S_EMPTY;
      main_sel    = M_BUBBLE;
      skid_bubble = 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state_nxt = S_ONE;
            main_sel  = M_IN;
          end
        end
        S_ONE: begin
          if (accept && out_ready) begin
            main_sel = M_IN;
          end else if (accept) begin
            state_nxt = S_FULL;
            skid_load = 1'b1;
          end else if (out_ready) begin
            // Going empty: bubble the control field so out_ctrl is never
            // a stale write enable while out_valid is low.
            state_nxt = S_EMPTY;
            main_sel  = M_BUBBLE;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            state_nxt   = S_ONE;
            main_sel    = M_SKID;
            skid_bubble = 1'b1;
          end
        end
        default: begin
          state_nxt = S_EMPTY;
          main_sel  = M_BUBBLE;
        end
      endcase
    end
  end

  // Main and skid storage. On a bubble only the control field is forced;
  // payload is don't-care while invalid and is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= BUBBLE_CTRL;
      main_data <= '0;
      skid_ctrl <= BUBBLE_CTRL;
      skid_data <= '0;
    end else begin
      case (main_sel)
        M_IN: begin
          main_ctrl <= in_ctrl;
          main_data <= in_data;
        end
        M_SKID: begin
          main_ctrl <= skid_ctrl;
          main_data <= skid_data;
        end
        M_BUBBLE: main_ctrl <= BUBBLE_CTRL;
        default: ;
      endcase
      if (skid_load) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end else if (skid_bubble) begin
        skid_ctrl <= BUBBLE_CTRL;
      end
    end
  end

  // Stall statistics: survives flush, clr_stats wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (out_valid_q && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
